// File: rtl/qed_inst_pkg.sv
// ============================================================================
// Module      : qed_inst_pkg
// Description : Shared constants and types for the SQED instruction generator.
//               It holds the RV32IM opcode, funct3 and funct7 fields, the
//               instruction class enum, the generator FSM state type and the
//               default LFSR feedback polynomial.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qed_inst_pkg;

    // Galois feedback taps and the non-zero state the LFSR returns to on reset
    localparam logic [31:0] c_lfsr_poly_default = 32'h80200003;
    localparam logic [31:0] c_lfsr_reset        = 32'h00000001;

    // Major opcodes
    localparam logic [6:0] c_op_r     = 7'b0110011;
    localparam logic [6:0] c_op_i     = 7'b0010011;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_nop   = 7'b1111111;

    // funct3 values (ALU, shifts, M-extension, word access)
    localparam logic [2:0] c_f3_add    = 3'b000;
    localparam logic [2:0] c_f3_sll    = 3'b001;
    localparam logic [2:0] c_f3_slt    = 3'b010;
    localparam logic [2:0] c_f3_sltu   = 3'b011;
    localparam logic [2:0] c_f3_xor    = 3'b100;
    localparam logic [2:0] c_f3_srl    = 3'b101;
    localparam logic [2:0] c_f3_or     = 3'b110;
    localparam logic [2:0] c_f3_and    = 3'b111;
    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_mulhu  = 3'b011;
    localparam logic [2:0] c_f3_word   = 3'b010;

    // funct7 values
    localparam logic [6:0] c_f7_base   = 7'b0000000;
    localparam logic [6:0] c_f7_alt    = 7'b0100000;
    localparam logic [6:0] c_f7_muldiv = 7'b0000001;

    // Instruction class selected by the low three LFSR bits
    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_NOP = 3'd4
    } inst_class_e;

    // Burst controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gen_state_e;

    // 0-2 R-type, 3-4 I-type, 5 load, 6 store, 7 custom NOP
    function automatic inst_class_e decode_class(input logic [2:0] sel);
        inst_class_e cls;
        case (sel)
            3'd0, 3'd1, 3'd2: cls = CLS_R;
            3'd3, 3'd4:       cls = CLS_I;
            3'd5:             cls = CLS_LW;
            3'd6:             cls = CLS_SW;
            default:          cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_gen_lfsr.sv
// ============================================================================
// Module      : inst_gen_lfsr
// Description : 32-bit right-shifting Galois LFSR with a synchronous seed load
//               and a single-step enable. A zero seed is replaced by 1 so that
//               the register can never lock up in the all-zero state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_gen_lfsr #(
    parameter logic [31:0] LFSR_POLY = qed_inst_pkg::c_lfsr_poly_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] value
);
    import qed_inst_pkg::*;

    logic [31:0] r_value;
    logic [31:0] w_next;
    logic [31:0] w_seed_safe;

    assign w_next      = {1'b0, r_value[31:1]} ^ (r_value[0] ? LFSR_POLY : 32'h0);
    assign w_seed_safe = (seed == 32'h0) ? c_lfsr_reset : seed;

    // State register: a load wins over a step, so a seed applied together with
    // a step lands unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= c_lfsr_reset;
        end else if (load) begin
            r_value <= w_seed_safe;
        end else if (step) begin
            r_value <= w_next;
        end
    end

    assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/inst_generator.sv
// ============================================================================
// Module      : inst_generator
// Description : Pseudo-random SQED-legal RV32IM instruction generator. The
//               burst FSM (IDLE/RUN/DONE) hands out one instruction per
//               valid/ready handshake. The instruction word is a pure function
//               of the current LFSR value, so it stays stable while stalled.
//               Configuration macro INST_GEN_MUL_EN adds MUL, MULH, MULHSU and
//               MULHU to the R-type table (14 entries instead of 10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_generator #(
    parameter logic [31:0] LFSR_POLY = qed_inst_pkg::c_lfsr_poly_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        seed_load,
    input  logic [31:0] seed,
    input  logic [15:0] burst_len,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] instruction,
    output logic        done,
    output logic [15:0] count
);
    import qed_inst_pkg::*;

`ifdef INST_GEN_MUL_EN
    localparam logic [3:0] c_r_op_count = 4'd14;
`else
    localparam logic [3:0] c_r_op_count = 4'd10;
`endif
    localparam logic [3:0] c_i_op_count = 4'd9;

    gen_state_e  r_state;
    gen_state_e  w_state_nxt;
    logic [15:0] r_count;
    logic [15:0] w_count_inc;
    logic        w_accept;
    logic        w_load;
    logic        w_clr_count;
    logic [31:0] w_r;

    // ------------------------------------------------------------------------
    // LFSR: seeded from IDLE, advanced once per accepted instruction
    // ------------------------------------------------------------------------
    inst_gen_lfsr #(
        .LFSR_POLY (LFSR_POLY)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .step  (w_accept),
        .seed  (seed),
        .value (w_r)
    );

    assign valid       = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign count       = r_count;
    assign w_accept    = valid && ready;
    assign w_count_inc = r_count + 16'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Abort takes priority over burst completion. Start is
    // only acted on in IDLE, so a start held through DONE is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clr_count = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = seed_load;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_clr_count = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept && (burst_len != 16'd0) && (w_count_inc == burst_len)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Accepted-instruction counter; an accept in the abort cycle still counts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (w_clr_count) begin
            r_count <= 16'd0;
        end else if (w_accept) begin
            r_count <= w_count_inc;
        end
    end

    // ------------------------------------------------------------------------
    // Encoder. Registers are drawn from 4-bit fields so they stay below x16.
    // ------------------------------------------------------------------------
    inst_class_e w_class;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [3:0]  w_r_idx;
    logic [3:0]  w_i_idx;
    logic [2:0]  w_r_f3;
    logic [6:0]  w_r_f7;
    logic [2:0]  w_i_f3;
    logic [11:0] w_i_imm;

    assign w_class = decode_class(w_r[2:0]);
    assign w_rd    = {1'b0, w_r[10:7]};
    assign w_rs1   = {1'b0, w_r[18:15]};
    assign w_rs2   = {1'b0, w_r[23:20]};
    // Out-of-range table indices fold back by a single subtraction
    assign w_r_idx = (w_r[6:3] >= c_r_op_count) ? (w_r[6:3] - c_r_op_count) : w_r[6:3];
    assign w_i_idx = (w_r[6:3] >= c_i_op_count) ? (w_r[6:3] - c_i_op_count) : w_r[6:3];

    // R-type operation table: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND [M ops]
    always_comb begin
        w_r_f3 = c_f3_add;
        w_r_f7 = c_f7_base;
        case (w_r_idx)
            4'd0:  w_r_f3 = c_f3_add;
            4'd1:  begin w_r_f3 = c_f3_add; w_r_f7 = c_f7_alt; end
            4'd2:  w_r_f3 = c_f3_sll;
            4'd3:  w_r_f3 = c_f3_slt;
            4'd4:  w_r_f3 = c_f3_sltu;
            4'd5:  w_r_f3 = c_f3_xor;
            4'd6:  w_r_f3 = c_f3_srl;
            4'd7:  begin w_r_f3 = c_f3_srl; w_r_f7 = c_f7_alt; end
            4'd8:  w_r_f3 = c_f3_or;
            4'd9:  w_r_f3 = c_f3_and;
`ifdef INST_GEN_MUL_EN
            4'd10: begin w_r_f3 = c_f3_mul;    w_r_f7 = c_f7_muldiv; end
            4'd11: begin w_r_f3 = c_f3_mulh;   w_r_f7 = c_f7_muldiv; end
            4'd12: begin w_r_f3 = c_f3_mulhsu; w_r_f7 = c_f7_muldiv; end
            4'd13: begin w_r_f3 = c_f3_mulhu;  w_r_f7 = c_f7_muldiv; end
`endif
            default: begin
                w_r_f3 = c_f3_add;
                w_r_f7 = c_f7_base;
            end
        endcase
    end

    // I-type operation table; shifts replace imm[11:5] with a fixed funct7
    always_comb begin
        w_i_f3  = c_f3_add;
        w_i_imm = w_r[31:20];
        case (w_i_idx)
            4'd0: w_i_f3 = c_f3_add;
            4'd1: w_i_f3 = c_f3_slt;
            4'd2: w_i_f3 = c_f3_sltu;
            4'd3: w_i_f3 = c_f3_xor;
            4'd4: w_i_f3 = c_f3_or;
            4'd5: w_i_f3 = c_f3_and;
            4'd6: begin w_i_f3 = c_f3_sll; w_i_imm = {c_f7_base, w_r[24:20]}; end
            4'd7: begin w_i_f3 = c_f3_srl; w_i_imm = {c_f7_base, w_r[24:20]}; end
            4'd8: begin w_i_f3 = c_f3_srl; w_i_imm = {c_f7_alt,  w_r[24:20]}; end
            default: begin
                w_i_f3  = c_f3_add;
                w_i_imm = w_r[31:20];
            end
        endcase
    end

    // Final instruction assembly; loads and stores use base x0 and keep the
    // top two immediate bits clear so every address stays in a small window
    always_comb begin
        instruction = {w_r[31:7], c_op_nop};
        case (w_class)
            CLS_R:   instruction = {w_r_f7, w_rs2, w_rs1, w_r_f3, w_rd, c_op_r};
            CLS_I:   instruction = {w_i_imm, w_rs1, w_i_f3, w_rd, c_op_i};
            CLS_LW:  instruction = {2'b00, w_r[29:20], 5'd0, c_f3_word, w_rd, c_op_load};
            CLS_SW:  instruction = {2'b00, w_r[29:25], w_rs2, 5'd0, c_f3_word, w_r[11:7], c_op_store};
            CLS_NOP: instruction = {w_r[31:7], c_op_nop};
            default: instruction = {w_r[31:7], c_op_nop};
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_generator.sv
// ============================================================================
// Module      : tb_inst_generator
// Description : Self-checking bench for inst_generator. A reference LFSR and
//               encoder predict each burst; expected words are queued when a
//               burst is launched and popped on every accepted handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_generator;

    localparam logic [31:0] POLY = 32'h80200003;
`ifdef INST_GEN_MUL_EN
    localparam int N_R = 14;
`else
    localparam int N_R = 10;
`endif

    localparam logic [2:0] R_F3 [0:13] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                          3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    localparam logic [6:0] R_F7 [0:13] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                          7'h20, 7'h00, 7'h00, 7'h01, 7'h01, 7'h01, 7'h01};
    localparam logic [2:0] I_F3 [0:8]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        seed_load;
    logic [31:0] seed;
    logic [15:0] burst_len;
    logic        ready;
    logic        valid;
    logic [31:0] instruction;
    logic        done;
    logic [15:0] count;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_lfsr = 32'h1;
    logic [15:0] exp_cnt = 16'd0;
    logic        done_seen = 1'b0;

    inst_generator #(.LFSR_POLY(POLY)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .seed_load   (seed_load),
        .seed        (seed),
        .burst_len   (burst_len),
        .ready       (ready),
        .valid       (valid),
        .instruction (instruction),
        .done        (done),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ POLY;
        return n;
    endfunction

    function automatic logic [31:0] ref_enc(input logic [31:0] r);
        int          c;
        int          k;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        c   = int'(r[2:0]);
        k   = int'(r[6:3]);
        rd  = {1'b0, r[10:7]};
        rs1 = {1'b0, r[18:15]};
        rs2 = {1'b0, r[23:20]};
        if (c <= 2) begin
            if (k >= N_R) k = k - N_R;
            return {R_F7[k], rs2, rs1, R_F3[k], rd, 7'b0110011};
        end else if (c <= 4) begin
            if (k >= 9) k = k - 9;
            imm = r[31:20];
            if (k == 6 || k == 7) imm = {7'b0000000, r[24:20]};
            if (k == 8)           imm = {7'b0100000, r[24:20]};
            return {imm, rs1, I_F3[k], rd, 7'b0010011};
        end else if (c == 5) begin
            return {2'b00, r[29:20], 5'd0, 3'b010, rd, 7'b0000011};
        end else if (c == 6) begin
            return {2'b00, r[29:25], rs2, 5'd0, 3'b010, r[11:7], 7'b0100011};
        end
        return {r[31:7], 7'b1111111};
    endfunction

    // SQED legality: registers below x16, memory base x0, top imm bits zero
    function automatic bit is_legal(input logic [31:0] ins);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        op = ins[6:0];
        f7 = ins[31:25];
        f3 = ins[14:12];
        case (op)
            7'b0110011: begin
                if (ins[11] || ins[19] || ins[24]) return 1'b0;
                if (f7 == 7'h00) return 1'b1;
                if (f7 == 7'h20) return (f3 == 3'd0 || f3 == 3'd5);
`ifdef INST_GEN_MUL_EN
                if (f7 == 7'h01) return (f3 <= 3'd3);
`endif
                return 1'b0;
            end
            7'b0010011: return !ins[11] && !ins[19];
            7'b0000011: return ins[19:15] == 5'd0 && f3 == 3'd2 && !ins[11] && ins[31:30] == 2'b00;
            7'b0100011: return ins[19:15] == 5'd0 && f3 == 3'd2 && !ins[24] && ins[31:30] == 2'b00;
            7'b1111111: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(ref_enc(m_lfsr));
            m_lfsr = ref_step(m_lfsr);
        end
    endtask

    // Called at a negedge: drive ready, score any handshake, advance a cycle
    task automatic step_cyc(input logic rdy);
        logic [31:0] e;
        ready = rdy;
        if (done) done_seen = 1'b1;
        if (valid && rdy) begin
            if (sb_q.size() == 0) begin
                chk("sb_depth", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("instr", instruction, e);
                chk("legal", 32'(is_legal(instruction)), 32'd1);
            end
            exp_cnt = exp_cnt + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_burst(input logic [31:0] s, input logic ld, input logic [15:0] bl, input int npush);
        seed      = s;
        seed_load = ld;
        start     = 1'b1;
        burst_len = bl;
        if (ld) m_lfsr = (s == 32'h0) ? 32'h1 : s;
        exp_cnt = 16'd0;
        push_burst(npush);
        step_cyc(1'b1);
        seed_load = 1'b0;
        start     = 1'b0;
    endtask

    task automatic run_burst(input int n, input int budget, input bit rnd);
        int cyc = 0;
        while (!done && cyc < budget) begin
            step_cyc(rnd ? ($urandom_range(0, 7) != 0) : 1'b1);
            cyc++;
        end
        chk("burst_done", 32'(done), 32'd1);
        chk("burst_valid", 32'(valid), 32'd0);
        chk("burst_cnt", 32'(count), n);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; seed_load = 1'b0;
        seed = 32'h0; burst_len = 16'd0; ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and r=1 encoding
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_instr", instruction, 32'h00000033);

        // Zero seed, three-instruction burst, done one cycle after last accept
        start_burst(32'h0, 1'b1, 16'd3, 3);
        chk("first_valid", 32'(valid), 32'd1);
        run_burst(3, 20, 1'b0);
        step_cyc(1'b1);
        chk("post_done", 32'(done), 32'd0);
        chk("post_idle", 32'(valid), 32'd0);

        // Start held during DONE must be ignored
        start_burst(32'h13572468, 1'b1, 16'd1, 1);
        run_burst(1, 10, 1'b0);
        start = 1'b1;
        step_cyc(1'b1);
        start = 1'b0;
        chk("done_start_valid", 32'(valid), 32'd0);
        chk("done_start_done", 32'(done), 32'd0);
        step_cyc(1'b1);
        chk("done_start_idle", 32'(valid), 32'd0);

        // Stall: word holds for five cycles, then the burst completes
        start_burst(32'hCAFEF00D, 1'b1, 16'd4, 4);
        step_cyc(1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", instruction, sb_q[0]);
            chk("stall_valid", 32'(valid), 32'd1);
            step_cyc(1'b0);
        end
        chk("stall_cnt", 32'(count), 32'd1);
        run_burst(4, 20, 1'b0);
        step_cyc(1'b0);

        // Reset mid-burst overrides everything
        start_burst(32'h0BADF00D, 1'b1, 16'd20, 20);
        repeat (3) step_cyc(1'b1);
        rst = 1'b1;
        step_cyc(1'b0);
        rst = 1'b0;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_instr", instruction, 32'h00000033);
        sb_q.delete();
        m_lfsr = 32'h1;

        // Unbounded burst: count wraps, no done, then abort
        start_burst(32'h12345678, 1'b1, 16'd0, 0);
        done_seen = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            if (exp_cnt == 16'hFFFF) chk("cnt_ffff", 32'(count), 32'h0000FFFF);
            if (i > 0 && exp_cnt == 16'h0000) chk("cnt_wrap0", 32'(count), 32'd0);
            push_burst(1);
            step_cyc(1'b1);
        end
        chk("no_done", 32'(done_seen), 32'd0);
        chk("cnt_70000", 32'(count), 32'(exp_cnt));
        abort = 1'b1;
        push_burst(1);
        step_cyc(1'b1);
        abort = 1'b0;
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cnt", 32'(count), 32'(exp_cnt));
        step_cyc(1'b1);
        chk("abort_hold", 32'(count), 32'(exp_cnt));
        chk("abort_sb", 32'(sb_q.size()), 32'd0);

        // Long random-ready burst from 0xDEADBEEF
        start_burst(32'hDEADBEEF, 1'b1, 16'd10000, 10000);
        run_burst(10000, 20000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_generator.md
INST_GENERATOR -- requirements
Module: inst_generator

Interface
REQ-001 SHALL have parameter LFSR_POLY, default 32'h80200003, Galois feedback taps of the 32-bit LFSR.
REQ-002 SHALL have ports, in order: clk input 1 (sole clock, rising edge); rst input 1 (synchronous, active-high reset).
REQ-003 SHALL have ports: start input 1 (begin burst); abort input 1 (stop burst); seed_load input 1; seed input 32 (LFSR seed).
REQ-004 SHALL have ports: burst_len input 16 (instructions per burst; 0 = unbounded); ready input 1 (consumer accepts).
REQ-005 SHALL have ports: valid output 1; instruction output 32 (RV32IM encoding); done output 1 (burst-complete pulse); count output 16 (accepted instructions this burst).

Function
REQ-006 SHALL implement FSM IDLE, RUN, DONE.
REQ-007 IDLE: valid=0; seed_load loads LFSR with seed, or 32'h00000001 when seed==0; start moves to RUN next cycle and clears count.
REQ-008 seed_load and start in the same cycle SHALL load the seed first; the first instruction derives from the new seed.
REQ-009 RUN: valid=1 from the first RUN cycle; accept = valid && ready.
REQ-010 While valid && !ready, instruction SHALL remain bit-stable; the LFSR advances one step only on accept.
REQ-011 On accept: count increments; when burst_len!=0 and the accept is the burst_len-th, next state = DONE.
REQ-012 burst_len==0: RUN never ends on its own; count wraps 16'hFFFF -> 0.
REQ-013 abort in RUN SHALL return to IDLE next cycle, valid=0, done=0, count held; a same-cycle accept still counts.
REQ-014 DONE: valid=0, done=1 for exactly one cycle, then IDLE; start in DONE SHALL be ignored.
REQ-015 Instruction SHALL be a combinational function of the current LFSR value r; class = r[2:0]: 0-2 R, 3-4 I, 5 LW, 6 SW, 7 NOP.
REQ-016 R: opcode 0110011; rd={0,r[10:7]}, rs1={0,r[18:15]}, rs2={0,r[23:20]}; op index r[6:3] into ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,MUL,MULH,MULHSU,MULHU; index>=N subtracts N.
REQ-017 I: opcode 0010011; rd/rs1 as R; op index r[6:3] into ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI, index>=9 subtracts 9; imm12=r[31:20]; shifts force funct7 (0000000 or 0100000 for SRAI), shamt=r[24:20].
REQ-018 LW: opcode 0000011, funct3 010, rs1=0, rd={0,r[10:7]}, imm12={00,r[29:20]}.
REQ-019 SW: opcode 0100011, funct3 010, rs1=0, rs2={0,r[23:20]}, instr[31:30]=00, remaining imm bits from r.
REQ-020 NOP: opcode 1111111, bits[31:7]=r[31:7].
REQ-021 Every emitted instruction SHALL satisfy the SQED legal-instruction set (registers < 16, LW/SW base x0, upper imm bits 00).

Reset
REQ-022 rst SHALL force state IDLE, valid=0, done=0, count=0, LFSR=32'h00000001; rst has priority over all inputs, including mid-burst.
REQ-023 instruction after reset SHALL equal the encoding of r=32'h00000001.

Configuration
REQ-024 Macro INST_GEN_MUL_EN defined: R-op table N=14 including MUL, MULH, MULHSU, MULHU.
REQ-025 INST_GEN_MUL_EN undefined: N=10; funct7=0000001 SHALL never appear; all other behaviour identical.

Structure
REQ-026 Package qed_inst_pkg SHALL hold opcode/funct3/funct7 constants, class enum, FSM state typedef, default LFSR_POLY.
REQ-027 LFSR SHALL be sub-module inst_gen_lfsr (load, step, seed, value); the encoder stays in inst_generator.

Verification
REQ-028 Reset, then r=1: instruction is class 1 R-type ADD x0,x0,x0 = 32'h00000033; valid=0, count=0.
REQ-029 seed=0, seed_load, start, ready=1, burst_len=3 -> exactly 3 accepts, count=3, done high one cycle after 3rd accept, then IDLE.
REQ-030 RUN with ready=0 for 5 cycles -> instruction constant; ready=1 -> next accept yields a different LFSR step.
REQ-031 burst_len=0, ready=1 for 70000 cycles -> no done, count wraps through 0; abort -> valid=0 next cycle.
REQ-032 10000 accepts, random ready, seed 32'hDEADBEEF -> all legal per REQ-021; without INST_GEN_MUL_EN zero MUL-family encodings.
